display_bcd_conv: RTL and testbench
===================================

Name: display_bcd_conv

Overview:
- Upstream feeder of the 8-digit seven-segment display driver. Captures CPU writes to the display register and produces the stable 32-bit `disp_data` word that the driver scans.
- Hex mode passes the word through unchanged.
- Decimal mode converts unsigned binary into 8 packed BCD digits with an iterative double-dabble (one bit per cycle). `disp_data` is updated atomically, so the display never shows intermediate values.

Parameters:
- DATA_W, 32: input and output word width. Fixed at 32; other values unsupported.
- N_DIGITS, 8: BCD digits, 4 bits each. N_DIGITS*4 == DATA_W.
- BCD_MAX, 99_999_999: largest decimal value displayable.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  one-cycle write strobe from CPU MMIO decode
- wr_data  in  32  value written
- wr_dec  in  1  format for this write: 0 = hex passthrough, 1 = unsigned decimal. Sampled with wr_en.
- disp_data  out  32  word to display driver, one 4-bit digit per nibble, [31:28] = leftmost digit
- busy  out  1  conversion in progress
- ovf  out  1  last displayed decimal value exceeded BCD_MAX
- pend  out  1  a write is queued behind the current conversion

Behaviour:
- Reset (asynchronous, any state): disp_data=0, busy=0, ovf=0, pend=0, state=IDLE, shift/count registers=0. An in-flight conversion is discarded; no partial result is ever written.
- States: IDLE, CONV.
- IDLE, wr_en=1, wr_dec=0: disp_data<=wr_data and ovf<=0 at that edge (latency 1). Stay IDLE.
- IDLE, wr_en=1, wr_dec=1, wr_data>BCD_MAX: disp_data<=32'hFFFF_FFFF and ovf<=1 at that edge (latency 1). No conversion. Stay IDLE.
- IDLE, wr_en=1, wr_dec=1, wr_data<=BCD_MAX: load bin_sr<=wr_data, bcd_sr<=0, cnt<=0. Go CONV; busy=1 from the next cycle.
- CONV, each cycle:
  - Every BCD nibble >=5 gets +3.
  - Then {bcd_sr,bin_sr} shifts left 1.
  - cnt increments.
- On the edge where cnt==31 (the 32nd shift): disp_data<=shifted bcd_sr, ovf<=0, state<=IDLE, busy<=0.
- Decimal latency: write at edge T0, result visible after edge T32; busy high for exactly 32 cycles.
- Arithmetic: add-3 is 4-bit, no carry between nibbles. Range check is an unsigned 32-bit compare.
- Write while CONV (either mode): captured into a single-entry pending register {data,dec}, pend=1. A further write while pending overwrites it; newest wins, older ones are dropped.
- Completion with pend=1: the next cycle is IDLE and the pending write is processed there exactly as a fresh write; pend clears at that edge.
- In that IDLE cycle, if wr_en=1 as well, the new write is taken and the pending one is discarded (pend cleared).
- Hex writes never bypass a conversion in flight: they queue, preserving order.
- disp_data changes only on the edges listed above; it is held stable at all other times.

Decomposition:
- Shared display package holds:
  - state encoding: IDLE, CONV
  - BCD_MAX constant
  - N_SHIFT=32
  - CNT_W=5
  - ERR_WORD=32'hFFFF_FFFF
- One sub-module: bcd_digit_adj, a combinational 4-bit add-3-if->=5 cell, instantiated N_DIGITS times in a generate loop.
- FSM, counter, pending register and output register stay in display_bcd_conv.

Test Plan:
- Hex write 32'h1234_ABCD, wr_dec=0 -> disp_data=32'h1234_ABCD one cycle later; busy never asserts; ovf=0.
- Decimal write 12_345_678 -> busy high 32 cycles, then disp_data=32'h1234_5678, ovf=0. disp_data unchanged (prior value) during all 32 busy cycles.
- Decimal boundary:
  - 99_999_999 -> 32'h9999_9999, ovf=0.
  - 100_000_000 -> 32'hFFFF_FFFF, ovf=1, latency 1.
  - 0 -> 32'h0000_0000 after 32 cycles.
- Back-to-back: decimal 42, then 3 cycles later hex 32'hAAAA_0001, then decimal 7 while still busy -> pend=1. Only 32'h0000_0042 then 32'h0000_0007 ever appear; the hex write is dropped. Total busy 64 cycles.
- Completion collision: pending decimal 5 queued, and a wr_en hex 32'hBEEF in the first IDLE cycle -> disp_data=32'h0000_BEEF, pend=0, no second conversion.
- Reset asserted at cnt==15 of a conversion of 87_654_321 -> outputs zero immediately and disp_data stays 0 after release. A new decimal write of 1 -> 32'h0000_0001.

Source files
------------

// File: rtl/display_bcd_conv_pkg.sv
// display_bcd_conv_pkg: shared state encoding and constants for the display BCD converter
package display_bcd_conv_pkg;
  typedef enum logic {IDLE, CONV} state_t;
  localparam logic [31:0] BCD_MAX = 32'd99_999_999;
  localparam int N_SHIFT = 32;
  localparam int CNT_W = 5;
  localparam logic [31:0] ERR_WORD = 32'hFFFF_FFFF;
endpackage

// File: rtl/display_bcd_conv_if.sv
// display_bcd_conv_if: CPU write port and display-side status of the BCD converter
interface display_bcd_conv_if #(parameter int DATA_W = 32);
  logic wr_en;
  logic wr_dec;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] disp_data;
  logic busy;
  logic ovf;
  logic pend;
  modport master (output wr_en, wr_dec, wr_data, input disp_data, busy, ovf, pend);
  modport slave (input wr_en, wr_dec, wr_data, output disp_data, busy, ovf, pend);
endinterface

// File: rtl/display_bcd_conv_bcd_digit_adj.sv
// bcd_digit_adj: double-dabble add-3 correction for one BCD nibble
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = d >= 4'd5 ? d + 4'd3 : d;
endmodule

// File: rtl/display_bcd_conv.sv
// display_bcd_conv: latches CPU display writes, hex passthrough or iterative binary-to-BCD
module display_bcd_conv
  import display_bcd_conv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_DIGITS = 8
) (
  input logic clk,
  input logic rst_n,
  display_bcd_conv_if.slave bus
);
  state_t state;
  logic [DATA_W-1:0] bin_sr, bcd_sr, adj, shifted, disp, pend_data, take_data;
  logic [CNT_W-1:0] cnt;
  logic ovf, pend, pend_dec, take, take_dec;
  for (genvar i = 0; i < N_DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (.d(bcd_sr[4*i +: 4]), .q(adj[4*i +: 4]));
  end
  assign shifted = {adj[DATA_W-2:0], bin_sr[DATA_W-1]};
  // a fresh write in the first idle cycle supersedes a queued one
  assign take = bus.wr_en | pend;
  assign take_data = bus.wr_en ? bus.wr_data : pend_data;
  assign take_dec = bus.wr_en ? bus.wr_dec : pend_dec;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bin_sr <= '0;
      bcd_sr <= '0;
      cnt <= '0;
      disp <= '0;
      ovf <= 1'b0;
      pend <= 1'b0;
      pend_data <= '0;
      pend_dec <= 1'b0;
    end else if (state == IDLE) begin
      pend <= 1'b0;
      if (take) begin
        if (!take_dec) begin
          disp <= take_data;
          ovf <= 1'b0;
        end else if (take_data > BCD_MAX) begin
          disp <= ERR_WORD;
          ovf <= 1'b1;
        end else begin
          bin_sr <= take_data;
          bcd_sr <= '0;
          cnt <= '0;
          state <= CONV;
        end
      end
    end else begin
      bcd_sr <= shifted;
      bin_sr <= bin_sr << 1;
      cnt <= cnt + 1'b1;
      if (bus.wr_en) begin
        pend <= 1'b1;
        pend_data <= bus.wr_data;
        pend_dec <= bus.wr_dec;
      end
      if (cnt == CNT_W'(N_SHIFT - 1)) begin
        disp <= shifted;
        ovf <= 1'b0;
        state <= IDLE;
      end
    end
  assign bus.disp_data = disp;
  assign bus.ovf = ovf;
  assign bus.pend = pend;
  assign bus.busy = state == CONV;
endmodule

// File: tb/tb_display_bcd_conv.sv
// tb_display_bcd_conv: directed vectors with a scoreboard of expected display updates
module tb_display_bcd_conv;
  typedef struct {logic [31:0] d; logic o;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  int busy_cycles = 0;
  exp_t sb[$];
  logic [31:0] p_disp;
  logic p_ovf, p_busy;
  display_bcd_conv_if bus ();
  display_bcd_conv dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.busy === 1'b1) busy_cycles++;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.disp_data !== p_disp || bus.ovf !== p_ovf || (p_busy && !bus.busy)) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_update disp=%h ovf=%b, nothing expected", bus.disp_data, bus.ovf);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (bus.disp_data !== e.d || bus.ovf !== e.o) begin
            n_err++;
            $display("FAIL display_update disp=%h ovf=%b, expected disp=%h ovf=%b", bus.disp_data, bus.ovf, e.d, e.o);
          end
        end
      end
    end
    p_disp = bus.disp_data;
    p_ovf = bus.ovf;
    p_busy = bus.busy;
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask
  task automatic write(input logic [31:0] d, input logic dec);
    bus.wr_en = 1'b1;
    bus.wr_data = d;
    bus.wr_dec = dec;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask
  task automatic run_dec(input string name, input logic [31:0] d, input logic [31:0] res);
    logic [31:0] held;
    logic moved;
    held = bus.disp_data;
    moved = 1'b0;
    busy_cycles = 0;
    sb.push_back('{res, 1'b0});
    write(d, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (!bus.busy) break;
      if (bus.disp_data !== held) moved = 1'b1;
      @(negedge clk);
    end
    check({name, "_busy_end"}, 32'(bus.busy), 32'd0);
    check({name, "_busy_cycles"}, busy_cycles, 32'd32);
    check({name, "_held"}, 32'(moved), 32'd0);
    check({name, "_result"}, bus.disp_data, res);
  endtask
  initial begin
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.wr_dec = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_disp", bus.disp_data, 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_ovf", 32'(bus.ovf), 32'd0);
    check("reset_pend", 32'(bus.pend), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    busy_cycles = 0;
    sb.push_back('{32'h1234_ABCD, 1'b0});
    write(32'h1234_ABCD, 1'b0);
    check("hex_data", bus.disp_data, 32'h1234_ABCD);
    check("hex_ovf", 32'(bus.ovf), 32'd0);
    repeat (3) @(negedge clk);
    check("hex_no_busy", busy_cycles, 32'd0);
    run_dec("dec_12345678", 32'd12_345_678, 32'h1234_5678);
    run_dec("dec_max", 32'd99_999_999, 32'h9999_9999);
    sb.push_back('{32'hFFFF_FFFF, 1'b1});
    busy_cycles = 0;
    write(32'd100_000_000, 1'b1);
    check("ovf_data", bus.disp_data, 32'hFFFF_FFFF);
    check("ovf_flag", 32'(bus.ovf), 32'd1);
    check("ovf_no_busy", 32'(bus.busy), 32'd0);
    run_dec("dec_zero", 32'd0, 32'h0000_0000);
    check("zero_ovf", 32'(bus.ovf), 32'd0);
    busy_cycles = 0;
    sb.push_back('{32'h0000_0042, 1'b0});
    sb.push_back('{32'h0000_0007, 1'b0});
    write(32'd42, 1'b1);
    repeat (2) @(negedge clk);
    write(32'hAAAA_0001, 1'b0);
    write(32'd7, 1'b1);
    check("b2b_pend", 32'(bus.pend), 32'd1);
    for (int i = 0; i < 100 && busy_cycles < 64; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("b2b_busy_cycles", busy_cycles, 32'd64);
    check("b2b_result", bus.disp_data, 32'h0000_0007);
    busy_cycles = 0;
    sb.push_back('{32'h0000_0009, 1'b0});
    sb.push_back('{32'h0000_BEEF, 1'b0});
    write(32'd9, 1'b1);
    repeat (2) @(negedge clk);
    write(32'd5, 1'b1);
    check("coll_pend_set", 32'(bus.pend), 32'd1);
    for (int i = 0; i < 40 && bus.busy; i++) @(negedge clk);
    check("coll_first_idle_pend", 32'(bus.pend), 32'd1);
    write(32'h0000_BEEF, 1'b0);
    check("coll_pend_clr", 32'(bus.pend), 32'd0);
    check("coll_data", bus.disp_data, 32'h0000_BEEF);
    repeat (5) @(negedge clk);
    check("coll_no_conv", busy_cycles, 32'd32);
    write(32'd87_654_321, 1'b1);
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_disp", bus.disp_data, 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_ovf", 32'(bus.ovf), 32'd0);
    check("rst_mid_pend", 32'(bus.pend), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_disp", bus.disp_data, 32'd0);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    run_dec("dec_one", 32'd1, 32'h0000_0001);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
